stg_pipe_reg: RTL and testbench
===============================

STG_PIPE_REG -- requirements
Module: stg_pipe_reg

Interface
REQ-001 Parameter ADDR_W, default `SIZE_ADDR, PC field width.
REQ-002 Parameter DATA_W, default `SIZE_DATA, instruction field width.
REQ-003 iw_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 iw_rst  in  1  asynchronous, active-high reset.
REQ-005 iw_pc  in  ADDR_W  upstream PC.
REQ-006 iw_instr  in  DATA_W  upstream instruction.
REQ-007 iw_valid  in  1  upstream PC/instr valid.
REQ-008 ow_ready  out  1  stage can accept this cycle.
REQ-009 ow_pc  out  ADDR_W  registered PC to downstream.
REQ-010 ow_instr  out  DATA_W  registered instruction to downstream.
REQ-011 ow_valid  out  1  ow_pc/ow_instr valid.
REQ-012 iw_ready  in  1  downstream accepts this cycle.
REQ-013 iw_flush  in  1  synchronous discard of all held entries.
REQ-014 iw_stall  in  1  synchronous hold; forces output to be treated as not consumed.
REQ-015 ow_count  out  2  number of valid entries held (0..2).

Function
REQ-016 Accept = iw_valid & ow_ready; consume = ow_valid & iw_ready & !iw_stall.
REQ-017 Latency iw->ow exactly 1 cycle when the stage is empty; sustained throughput 1 entry/cycle while iw_ready=1, iw_stall=0.
REQ-018 Whenever ow_valid=0, ow_pc and ow_instr SHALL read all-zero (bubble = NOP 0).
REQ-019 Priority per edge: iw_rst > iw_flush > iw_stall > handshake.
REQ-020 iw_flush=1: clear all entries (valid=0, fields zero) next edge; a simultaneous accept is discarded; ow_ready is not gated by flush.
REQ-021 iw_stall=1 (no flush): held entries unchanged; accepts still permitted while ow_ready=1.
REQ-022 Never drop, duplicate, or reorder an accepted entry; ow_count never exceeds capacity.
REQ-023 Output register entry M, optional skid entry S; ow_valid = M valid.

Reset
REQ-024 While iw_rst=1, immediately: ow_valid=0, ow_pc=0, ow_instr=0, ow_count=0, S cleared; ow_ready=1 after reset (iw_ready-independent in skid mode).
REQ-025 Reset asserted mid-transfer discards all entries; no partial state survives.

Configuration
REQ-026 Macro STG_SKID_EN defined: capacity 2 (M+S); ow_ready = !S_valid, purely registered, no combinational path from iw_ready/iw_stall to ow_ready.
REQ-027 STG_SKID_EN rules: accept & !consume & M valid -> S<=input; consume & S valid -> M<=S, S cleared; consume or M empty with S empty -> M<=input if accepted else M cleared.
REQ-028 STG_SKID_EN undefined: capacity 1, S absent; ow_ready = !M_valid | (iw_ready & !iw_stall) (combinational); ow_count in {0,1}.

Structure
REQ-029 ADDR_W/DATA_W defaults from `SIZE_ADDR/`SIZE_DATA in src/sizes.vh; bubble value from src/opcodes.vh; no new shared constants.
REQ-030 Skid entry implemented as sub-module stg_skid_buf, instantiated only under STG_SKID_EN.

Verification
REQ-031 Reset: iw_rst pulse mid-stream with M/S full -> ow_valid=0, ow_pc=0, ow_instr=0, ow_count=0 without a clock edge.
REQ-032 Streaming: pc 0x100,0x104,0x108 valid back-to-back, iw_ready=1 -> same values on ow_pc one cycle later each, no bubbles.
REQ-033 Backpressure (skid): stream 0x200,0x204, iw_ready=0 at cycle 1 -> ow_count=2, ow_ready=0; release -> 0x200 then 0x204, none lost.
REQ-034 Stall: iw_stall=1 for 3 cycles with ow_pc=0x300 and iw_ready=1 -> ow_pc held 0x300, ow_valid=1, no consume counted.
REQ-035 Flush+accept same cycle: iw_flush=1, iw_valid=1 pc 0x400 -> next cycle ow_valid=0, ow_pc=0, ow_instr=0, ow_count=0.
REQ-036 Random valid/ready/stall 10k cycles, both macro settings -> scoreboard in-order match, zero loss/duplication.

Source files
------------

// File: rtl/stg_pipe_reg_pkg.sv
// Shared types and helpers for the stg_pipe_reg pipeline stage.
// The skid entry (built only when STG_SKID_EN is defined) is driven by a small
// operation code so the top keeps all sequencing decisions in one place.
package stg_pipe_reg_pkg;

    // Operation applied to the skid entry on the next clock edge.
    typedef enum logic [1:0] {
        SkidHold,   // keep current contents
        SkidLoad,   // capture upstream PC/instr
        SkidPop,    // contents moved into the output entry
        SkidClear   // flush
    } skid_op_e;

    // Occupancy of the stage: output entry plus optional skid entry.
    function automatic logic [1:0] entry_count(input logic m_valid, input logic s_valid);
        return {1'b0, m_valid} + {1'b0, s_valid};
    endfunction

endpackage

// File: rtl/stg_skid_buf.sv
// Single skid entry for stg_pipe_reg. Holds one PC/instr pair that arrived
// while the output entry was blocked. Fields read zero whenever the entry is
// empty so a pop never leaks stale data into the output entry.
module stg_skid_buf
    import stg_pipe_reg_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  skid_op_e          iw_op,
    input  logic [ADDR_W-1:0] iw_pc,
    input  logic [DATA_W-1:0] iw_instr,
    output logic              ow_valid,
    output logic [ADDR_W-1:0] ow_pc,
    output logic [DATA_W-1:0] ow_instr
);

    logic              s_valid_q;
    logic [ADDR_W-1:0] s_pc_q;
    logic [DATA_W-1:0] s_instr_q;

    // Skid entry state: load, empty on pop/flush, otherwise hold.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            s_valid_q <= 1'b0;
            s_pc_q    <= '0;
            s_instr_q <= '0;
        end else begin
            unique case (iw_op)
                SkidLoad: begin
                    s_valid_q <= 1'b1;
                    s_pc_q    <= iw_pc;
                    s_instr_q <= iw_instr;
                end
                SkidPop, SkidClear: begin
                    s_valid_q <= 1'b0;
                    s_pc_q    <= '0;
                    s_instr_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ow_valid = s_valid_q;
    assign ow_pc    = s_pc_q;
    assign ow_instr = s_instr_q;

endmodule

// File: rtl/stg_pipe_reg.sv
// Pipeline register stage carrying PC + instruction with valid/ready handshake,
// synchronous flush and stall.
// Build option: define STG_SKID_EN to add a skid entry (capacity 2, fully
// registered ow_ready). Without it the stage holds one entry and ow_ready is
// combinational from iw_ready/iw_stall.
// Empty entries always hold zero so downstream sees a NOP bubble.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module stg_pipe_reg
    import stg_pipe_reg_pkg::*;
#(
    parameter int unsigned ADDR_W = `SIZE_ADDR,
    parameter int unsigned DATA_W = `SIZE_DATA
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic [ADDR_W-1:0] iw_pc,
    input  logic [DATA_W-1:0] iw_instr,
    input  logic              iw_valid,
    output logic              ow_ready,
    output logic [ADDR_W-1:0] ow_pc,
    output logic [DATA_W-1:0] ow_instr,
    output logic              ow_valid,
    input  logic              iw_ready,
    input  logic              iw_flush,
    input  logic              iw_stall,
    output logic [1:0]        ow_count
);

    logic              m_valid_q, m_valid_d;
    logic [ADDR_W-1:0] m_pc_q, m_pc_d;
    logic [DATA_W-1:0] m_instr_q, m_instr_d;
    logic              s_valid;
    logic              accept;
    logic              consume;

    assign accept  = iw_valid & ow_ready;
    assign consume = m_valid_q & iw_ready & ~iw_stall;

`ifdef STG_SKID_EN
    logic [ADDR_W-1:0] s_pc;
    logic [DATA_W-1:0] s_instr;
    skid_op_e          s_op;

    // Ready depends only on skid occupancy, so it is a pure register output.
    assign ow_ready = ~s_valid;

    // Output-entry next state and skid operation.
    always_comb begin
        m_valid_d = m_valid_q;
        m_pc_d    = m_pc_q;
        m_instr_d = m_instr_q;
        s_op      = SkidHold;
        if (iw_flush) begin
            m_valid_d = 1'b0;
            m_pc_d    = '0;
            m_instr_d = '0;
            s_op      = SkidClear;
        end else if (consume && s_valid) begin
            // ow_ready is low here, so no accept can collide with the pop.
            m_valid_d = 1'b1;
            m_pc_d    = s_pc;
            m_instr_d = s_instr;
            s_op      = SkidPop;
        end else if (consume || !m_valid_q) begin
            m_valid_d = accept;
            m_pc_d    = accept ? iw_pc : '0;
            m_instr_d = accept ? iw_instr : '0;
        end else if (accept) begin
            // Output entry is held (blocked or stalled): park the new entry.
            s_op = SkidLoad;
        end
    end

    stg_skid_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_skid (
        .iw_clk   (iw_clk),
        .iw_rst   (iw_rst),
        .iw_op    (s_op),
        .iw_pc    (iw_pc),
        .iw_instr (iw_instr),
        .ow_valid (s_valid),
        .ow_pc    (s_pc),
        .ow_instr (s_instr)
    );
`else
    assign s_valid = 1'b0;

    // Single entry: can take a new one when empty or when it leaves this cycle.
    assign ow_ready = ~m_valid_q | (iw_ready & ~iw_stall);

    // Output-entry next state: flush wins, then accept, then drain on consume.
    always_comb begin
        m_valid_d = m_valid_q;
        m_pc_d    = m_pc_q;
        m_instr_d = m_instr_q;
        if (iw_flush) begin
            m_valid_d = 1'b0;
            m_pc_d    = '0;
            m_instr_d = '0;
        end else if (accept) begin
            m_valid_d = 1'b1;
            m_pc_d    = iw_pc;
            m_instr_d = iw_instr;
        end else if (consume) begin
            m_valid_d = 1'b0;
            m_pc_d    = '0;
            m_instr_d = '0;
        end
    end
`endif

    // Output entry register; async reset empties it immediately.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            m_valid_q <= 1'b0;
            m_pc_q    <= '0;
            m_instr_q <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_pc_q    <= m_pc_d;
            m_instr_q <= m_instr_d;
        end
    end

    assign ow_valid = m_valid_q;
    assign ow_pc    = m_pc_q;
    assign ow_instr = m_instr_q;
    assign ow_count = entry_count(m_valid_q, s_valid);

endmodule

// File: tb/tb_stg_pipe_reg.sv
// Self-checking bench for stg_pipe_reg. Works for either build; expectations
// that depend on capacity follow STG_SKID_EN. A queue scoreboard models the
// stage: entries are pushed on predicted accept and popped on predicted consume.
module tb_stg_pipe_reg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef STG_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } ent_t;

    logic          iw_clk = 1'b0;
    logic          iw_rst = 1'b1;
    logic [AW-1:0] iw_pc = '0;
    logic [DW-1:0] iw_instr = '0;
    logic          iw_valid = 1'b0;
    logic          ow_ready;
    logic [AW-1:0] ow_pc;
    logic [DW-1:0] ow_instr;
    logic          ow_valid;
    logic          iw_ready = 1'b0;
    logic          iw_flush = 1'b0;
    logic          iw_stall = 1'b0;
    logic [1:0]    ow_count;

    ent_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   consumed = 0;

    stg_pipe_reg #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .iw_clk   (iw_clk),
        .iw_rst   (iw_rst),
        .iw_pc    (iw_pc),
        .iw_instr (iw_instr),
        .iw_valid (iw_valid),
        .ow_ready (ow_ready),
        .ow_pc    (ow_pc),
        .ow_instr (ow_instr),
        .ow_valid (ow_valid),
        .iw_ready (iw_ready),
        .iw_flush (iw_flush),
        .iw_stall (iw_stall),
        .ow_count (ow_count)
    );

    always #5 iw_clk = ~iw_clk;

    function automatic logic [DW-1:0] ins_of(input logic [AW-1:0] pc);
        return pc ^ 32'h1357_0000;
    endfunction

    // Expected ready from model occupancy and current downstream inputs.
    function automatic logic model_ready();
`ifdef STG_SKID_EN
        return sb.size() < 2;
`else
        return (sb.size() == 0) || (iw_ready && !iw_stall);
`endif
    endfunction

    // Drive inputs for one cycle and wait to the sampling point.
    task automatic apply(input logic v, input logic [AW-1:0] pc, input logic [DW-1:0] ins,
                         input logic rdy, input logic stl, input logic fl);
        iw_valid = v;
        iw_pc    = pc;
        iw_instr = ins;
        iw_ready = rdy;
        iw_stall = stl;
        iw_flush = fl;
        @(negedge iw_clk);
    endtask

    // Advance through the clock edge and update the scoreboard.
    task automatic commit();
        logic acc;
        logic con;
        ent_t e;
        acc = iw_valid && model_ready();
        con = (sb.size() > 0) && iw_ready && !iw_stall;
        e.pc = iw_pc;
        e.instr = iw_instr;
        @(posedge iw_clk);
        #1;
        if (iw_flush) begin
            sb.delete();
        end else begin
            if (con) begin
                void'(sb.pop_front());
                consumed++;
            end
            if (acc) sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (ow_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ow_valid); end
        checks++;
        if (ow_pc !== '0 || ow_instr !== '0) begin
            errors++; $display("FAIL reset_fields: got pc=%h instr=%h want 0", ow_pc, ow_instr);
        end
        checks++;
        if (ow_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", ow_count); end
        checks++;
        if (ow_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ow_ready); end
        @(negedge iw_clk);
        iw_rst = 1'b0;
        @(posedge iw_clk);
        #1;
    endtask

    task automatic test_streaming();
        logic [AW-1:0] pcs[3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) apply(1'b1, pcs[i], ins_of(pcs[i]), 1'b1, 1'b0, 1'b0);
            else       apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            if (i == 0) begin
                checks++;
                if (ow_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", ow_valid); end
            end else begin
                checks++;
                if (ow_valid !== 1'b1 || ow_pc !== pcs[i-1] || ow_instr !== ins_of(pcs[i-1])) begin
                    errors++;
                    $display("FAIL stream_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                             i, ow_valid, ow_pc, ow_instr, pcs[i-1], ins_of(pcs[i-1]));
                end
            end
            commit();
        end
        apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ow_valid !== 1'b0 || ow_pc !== '0) begin
            errors++; $display("FAIL stream_drained: got v=%b pc=%h want v=0 pc=0", ow_valid, ow_pc);
        end
        commit();
    endtask

    task automatic test_backpressure();
        apply(1'b1, 32'h200, ins_of(32'h200), 1'b0, 1'b0, 1'b0);
        commit();
        apply(1'b1, 32'h204, ins_of(32'h204), 1'b0, 1'b0, 1'b0);
        checks++;
        if (ow_pc !== 32'h200) begin errors++; $display("FAIL bp_head: got %h want 200", ow_pc); end
        commit();
        apply(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ow_count !== 2'(CAP)) begin errors++; $display("FAIL bp_count: got %0d want %0d", ow_count, CAP); end
        checks++;
        if (ow_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", ow_ready); end
        commit();
        apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ow_pc !== 32'h200 || ow_valid !== 1'b1) begin
            errors++; $display("FAIL bp_first: got v=%b pc=%h want v=1 pc=200", ow_valid, ow_pc);
        end
        commit();
        apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
`ifdef STG_SKID_EN
        if (ow_pc !== 32'h204 || ow_valid !== 1'b1 || ow_instr !== ins_of(32'h204)) begin
            errors++; $display("FAIL bp_second: got v=%b pc=%h want v=1 pc=204", ow_valid, ow_pc);
        end
`else
        if (ow_valid !== 1'b0 || ow_pc !== '0) begin
            errors++; $display("FAIL bp_second: got v=%b pc=%h want v=0 pc=0", ow_valid, ow_pc);
        end
`endif
        commit();
        apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ow_count !== 2'd0) begin errors++; $display("FAIL bp_drain: got %0d want 0", ow_count); end
        commit();
    endtask

    task automatic test_stall();
        int c0;
        apply(1'b1, 32'h300, ins_of(32'h300), 1'b1, 1'b0, 1'b0);
        commit();
        c0 = consumed;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
            checks++;
            if (ow_pc !== 32'h300 || ow_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold_%0d: got v=%b pc=%h want v=1 pc=300", i, ow_valid, ow_pc);
            end
            commit();
        end
        checks++;
        if (consumed !== c0) begin errors++; $display("FAIL stall_consume: got %0d want %0d", consumed, c0); end
        apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ow_pc !== 32'h300) begin errors++; $display("FAIL stall_release: got %h want 300", ow_pc); end
        commit();
        apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ow_valid !== 1'b0) begin errors++; $display("FAIL stall_gone: got %b want 0", ow_valid); end
        commit();
    endtask

    task automatic test_flush();
        apply(1'b1, 32'h3F0, ins_of(32'h3F0), 1'b0, 1'b0, 1'b0);
        commit();
        apply(1'b1, 32'h400, ins_of(32'h400), 1'b0, 1'b0, 1'b1);
        commit();
        apply(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ow_valid !== 1'b0 || ow_pc !== '0 || ow_instr !== '0 || ow_count !== 2'd0) begin
            errors++;
            $display("FAIL flush_accept: got v=%b pc=%h instr=%h cnt=%0d want all 0",
                     ow_valid, ow_pc, ow_instr, ow_count);
        end
        checks++;
        if (ow_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", ow_ready); end
        commit();
    endtask

    task automatic test_reset_midstream();
        apply(1'b1, 32'h500, ins_of(32'h500), 1'b0, 1'b0, 1'b0);
        commit();
        apply(1'b1, 32'h504, ins_of(32'h504), 1'b0, 1'b0, 1'b0);
        commit();
        iw_valid = 1'b0;
        #2;
        iw_rst = 1'b1;
        #1;
        checks++;
        if (ow_valid !== 1'b0 || ow_pc !== '0 || ow_instr !== '0 || ow_count !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid: got v=%b pc=%h instr=%h cnt=%0d want all 0",
                     ow_valid, ow_pc, ow_instr, ow_count);
        end
        checks++;
        if (ow_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", ow_ready); end
        sb.delete();
        @(negedge iw_clk);
        iw_rst = 1'b0;
        @(posedge iw_clk);
        #1;
    endtask

    task automatic test_random();
        logic          v, rdy, stl, fl;
        logic [AW-1:0] pc;
        logic          exp_valid;
        ent_t          head;
        int            bad = 0;
        for (int n = 0; n < 10000; n++) begin
            v   = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 65);
            stl = ($urandom_range(0, 99) < 15);
            fl  = ($urandom_range(0, 99) < 3);
            pc  = $urandom();
            apply(v, pc, ins_of(pc) ^ DW'(n), rdy, stl, fl);
            exp_valid = sb.size() > 0;
            head = exp_valid ? sb[0] : '0;
            checks++;
            if (ow_valid !== exp_valid || ow_pc !== head.pc || ow_instr !== head.instr ||
                ow_count !== 2'(sb.size()) || ow_ready !== model_ready()) begin
                errors++;
                if (bad < 10) begin
                    $display("FAIL rand_%0d: got v=%b pc=%h instr=%h cnt=%0d rdy=%b want v=%b pc=%h instr=%h cnt=%0d rdy=%b",
                             n, ow_valid, ow_pc, ow_instr, ow_count, ow_ready,
                             exp_valid, head.pc, head.instr, sb.size(), model_ready());
                end
                bad++;
            end
            commit();
        end
        for (int i = 0; i < CAP + 1; i++) begin
            apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            commit();
        end
        apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ow_count !== 2'd0 || ow_valid !== 1'b0) begin
            errors++; $display("FAIL rand_drain: got cnt=%0d v=%b want 0", ow_count, ow_valid);
        end
        commit();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
